// File: rtl/pc_fetch.sv
// Program counter and instruction/data fetch stage: holds the PC, issues one RAM read per
// request and presents the returned word with a single-cycle strobe after a fixed latency.
module pc_fetch #(
  parameter int unsigned             DWIDTH   = 16,
  parameter int unsigned             AWIDTH   = 8,
  parameter int unsigned             RAM_LAT  = 2,
  parameter logic        [AWIDTH-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_pc_pulse,
  input  logic [1:0]        pc_ctrl,
  input  logic              z_flag,
  input  logic [AWIDTH-1:0] offset_addr,
  input  logic              addr_sel,
  input  logic              en_ram_in,
  output logic [AWIDTH-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [DWIDTH-1:0] ram_rdata,
  output logic [DWIDTH-1:0] ins,
  output logic              en_ram_out,
  output logic              busy,
  output logic [AWIDTH-1:0] pc
);

  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [AWIDTH-1:0]   pc_q, pc_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic                rd_q, rd_d;
  logic [DWIDTH-1:0]   ins_q, ins_d;
  logic                out_q, out_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      ins_q   <= '0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      ins_q   <= ins_d;
      out_q   <= out_d;
    end
  end

  // PC update is independent of the fetch FSM; arithmetic wraps modulo 2^AWIDTH.
  always_comb begin
    pc_d = pc_q;
    if (en_pc_pulse) begin
      case (pc_ctrl)
        2'b00:   pc_d = pc_q;
        2'b01:   pc_d = pc_q + 1'b1;
        2'b10:   pc_d = offset_addr;
        default: pc_d = z_flag ? offset_addr : pc_q + 1'b1;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rd_d    = 1'b0;
    ins_d   = ins_q;
    out_d   = 1'b0;
    case (state_q)
      StIdle: begin
        // Fetch address uses the pre-update PC when a PC command lands on the same edge.
        if (en_ram_in) begin
          addr_d  = addr_sel ? offset_addr : pc_q;
          rd_d    = 1'b1;
          cnt_d   = CntW'(RAM_LAT);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          ins_d   = ram_rdata;
          out_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign ram_addr   = addr_q;
  assign ram_rd     = rd_q;
  assign ins        = ins_q;
  assign en_ram_out = out_q;
  assign busy       = (state_q != StIdle);
  assign pc         = pc_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Randomised and directed bench for pc_fetch against a timestamp-based model of the PC and
// the request/strobe timeline, with a fixed-latency RAM model.
module tb_pc_fetch;

  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 8;
  localparam int unsigned LAT = 2;
  localparam logic [7:0]  RPC = 8'h10;

  logic          clk = 1'b0;
  logic          rst;
  logic          en_pc_pulse;
  logic [1:0]    pc_ctrl;
  logic          z_flag;
  logic [AW-1:0] offset_addr;
  logic          addr_sel;
  logic          en_ram_in;
  logic [AW-1:0] ram_addr;
  logic          ram_rd;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] ins;
  logic          en_ram_out;
  logic          busy;
  logic [AW-1:0] pc;

  pc_fetch #(
    .DWIDTH  (DW),
    .AWIDTH  (AW),
    .RAM_LAT (LAT),
    .RESET_PC(RPC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en_pc_pulse(en_pc_pulse),
    .pc_ctrl    (pc_ctrl),
    .z_flag     (z_flag),
    .offset_addr(offset_addr),
    .addr_sel   (addr_sel),
    .en_ram_in  (en_ram_in),
    .ram_addr   (ram_addr),
    .ram_rd     (ram_rd),
    .ram_rdata  (ram_rdata),
    .ins        (ins),
    .en_ram_out (en_ram_out),
    .busy       (busy),
    .pc         (pc)
  );

  always #5 clk = ~clk;

  // RAM: data is valid only in the single cycle LAT cycles after the sampling edge.
  logic [DW-1:0] mem [256];
  int            rd_cnt;
  logic [AW-1:0] rd_addr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt  <= 0;
      rd_addr <= '0;
    end else if (ram_rd) begin
      rd_cnt  <= LAT;
      rd_addr <= ram_addr;
    end else if (rd_cnt > 0) begin
      rd_cnt <= rd_cnt - 1;
    end
  end

  assign ram_rdata = (rd_cnt == 1) ? mem[rd_addr] : 16'hDEAD;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: PC value plus absolute cycle numbers of the next read strobe and output strobe.
  int            cyc;
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_ins;
  logic [DW-1:0] pend;
  int            rd_at;
  int            out_at;
  int            busy_to;

  task automatic model_reset();
    m_pc    = RPC;
    m_addr  = '0;
    m_ins   = '0;
    pend    = '0;
    rd_at   = -1;
    out_at  = -1;
    busy_to = -1;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".pc"},         32'(pc),         32'(m_pc));
    check_eq({tag, ".ram_rd"},     32'(ram_rd),     32'(cyc == rd_at));
    check_eq({tag, ".ram_addr"},   32'(ram_addr),   32'(m_addr));
    check_eq({tag, ".ins"},        32'(ins),        32'(m_ins));
    check_eq({tag, ".en_ram_out"}, 32'(en_ram_out), 32'(cyc == out_at));
    check_eq({tag, ".busy"},       32'(busy),       32'(cyc <= busy_to));
  endtask

  task automatic step(input string tag, input logic pp, input logic [1:0] ctrl, input logic z,
                      input logic [AW-1:0] off, input logic as, input logic req);
    int e;
    en_pc_pulse = pp;
    pc_ctrl     = ctrl;
    z_flag      = z;
    offset_addr = off;
    addr_sel    = as;
    en_ram_in   = req;
    @(posedge clk);
    e = cyc;
    if (!rst) begin
      if (req && e > busy_to) begin
        m_addr  = as ? off : m_pc;
        pend    = mem[m_addr];
        rd_at   = e + 1;
        out_at  = e + 2 + LAT;
        busy_to = out_at;
      end
      if (pp) begin
        if (ctrl == 2'b01 || (ctrl == 2'b11 && !z)) m_pc = m_pc + 8'd1;
        else if (ctrl[1]) m_pc = off;
      end
    end
    cyc = e + 1;
    if (cyc == out_at) m_ins = pend;
    #1;
    check_all(tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step("idle", 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic set_pc(input logic [AW-1:0] v);
    step("set_pc", 1'b1, 2'b10, 1'b0, v, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[8'h05] = 16'hA3C1;
    en_pc_pulse = 1'b0;
    pc_ctrl     = 2'b00;
    z_flag      = 1'b0;
    offset_addr = '0;
    addr_sel    = 1'b0;
    en_ram_in   = 1'b0;
    cyc         = 0;
    rst         = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all("reset");

    // PC command sequence, including wrap.
    set_pc(8'hFE);
    step("inc", 1'b1, 2'b01, 1'b0, 8'h00, 1'b0, 1'b0);
    check_eq("pc_ff", 32'(pc), 32'h0FF);
    step("wrap", 1'b1, 2'b01, 1'b0, 8'h00, 1'b0, 1'b0);
    check_eq("pc_wrap", 32'(pc), 32'h000);
    step("jmp", 1'b1, 2'b10, 1'b0, 8'h40, 1'b0, 1'b0);
    check_eq("pc_jmp", 32'(pc), 32'h040);
    step("bz0", 1'b1, 2'b11, 1'b0, 8'h20, 1'b0, 1'b0);
    check_eq("pc_bz0", 32'(pc), 32'h041);
    step("bz1", 1'b1, 2'b11, 1'b1, 8'h20, 1'b0, 1'b0);
    check_eq("pc_bz1", 32'(pc), 32'h020);

    // Sequential fetch from PC 0x05.
    set_pc(8'h05);
    step("seq_req", 1'b0, 2'b00, 1'b0, 8'h99, 1'b0, 1'b1);
    check_eq("seq_rd", 32'(ram_rd), 32'h1);
    check_eq("seq_addr", 32'(ram_addr), 32'h05);
    idle(LAT + 1);
    check_eq("seq_strobe", 32'(en_ram_out), 32'h1);
    check_eq("seq_ins", 32'(ins), 32'hA3C1);
    idle(2);

    // Data-address fetch leaves the PC alone.
    set_pc(8'h03);
    step("data_req", 1'b0, 2'b00, 1'b0, 8'h7E, 1'b1, 1'b1);
    check_eq("data_addr", 32'(ram_addr), 32'h7E);
    check_eq("data_pc", 32'(pc), 32'h03);
    idle(LAT + 3);

    // Collision: request during WAIT is dropped; request right after DONE is accepted.
    step("col_req", 1'b0, 2'b00, 1'b0, 8'h11, 1'b1, 1'b1);
    step("col_ign", 1'b0, 2'b00, 1'b0, 8'h22, 1'b1, 1'b1);
    idle(LAT);
    step("col_done", 1'b0, 2'b00, 1'b0, 8'h33, 1'b1, 1'b1);
    step("col_next", 1'b0, 2'b00, 1'b0, 8'h44, 1'b1, 1'b1);
    check_eq("col_next_addr", 32'(ram_addr), 32'h44);
    idle(LAT + 3);

    // PC command and fetch on the same edge.
    set_pc(8'h08);
    step("simul", 1'b1, 2'b01, 1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("simul_addr", 32'(ram_addr), 32'h08);
    check_eq("simul_pc", 32'(pc), 32'h09);
    idle(LAT + 3);

    // Asynchronous reset in the middle of WAIT.
    step("abort_req", 1'b1, 2'b10, 1'b0, 8'h55, 1'b1, 1'b1);
    idle(1);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    check_eq("async_rst_pc", 32'(pc), 32'h10);
    step("rst_hold", 1'b0, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    idle(LAT + 4);

    // Randomised traffic.
    for (int i = 0; i < 800; i++) begin
      step("rand", ($urandom_range(3) == 0), 2'($urandom), 1'($urandom), 8'($urandom),
           1'($urandom), ($urandom_range(2) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
